// File: rtl/bram_read_arbiter_pkg.sv
// rtl/bram_read_arbiter_pkg.sv - shared types and constants for the weight BRAM read arbiter
package bram_read_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_W          = 8;
    localparam int DEF_RD_LAT     = 2;

    // Per-layer weight regions inside the shared BRAM
    localparam int LAYER0_BASE    = 0;
    localparam int LAYER1_1_BASE  = 1024;
    localparam int LAYER1_2_BASE  = 2048;
    localparam int LAYER1_3_BASE  = 4096;
    localparam int LAYER2_BASE    = 8192;

endpackage

// File: rtl/bram_read_arbiter_rr.sv
// rtl/bram_read_arbiter_rr.sv - combinational round-robin winner select starting at ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [ID_W-1:0]    win_idx,
    output logic               any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any              = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// rtl/bram_read_arbiter.sv - round-robin burst reader sharing one weight BRAM among NUM_REQ loaders
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_W      = 16,
    parameter int W          = DEF_W,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic                        rd_valid,
    output logic [ID_W-1:0]             rd_id,
    output logic [W-1:0]                rd_data,
    output logic                        rd_last,
    output logic                        bram_en,
    output logic                        bram_ren,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    input  logic [W-1:0]                bram_dout
);

    arb_state_t              state, state_n;
    logic [ID_W-1:0]         rr_ptr, id_q, win_idx;
    logic [NUM_REQ-1:0]      win_oh, grant_n;
    logic                    win_any;
    logic [ADDR_WIDTH-1:0]   win_base, addr_q;
    logic [LEN_W-1:0]        win_len, cnt_q;
    logic                    zl_q, zl_done_q;
    logic [ID_W-1:0]         iss_id;
    logic                    iss_last;
    logic [RD_LAT-1:0]       pv, pl;
    logic [ID_W-1:0]         pid [RD_LAT];
    logic                    issue, last_issue, out_last, drain_exit;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req        (req),
        .ptr        (rr_ptr),
        .win_onehot (win_oh),
        .win_idx    (win_idx),
        .any        (win_any)
    );

    assign win_base   = req_base[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len    = req_len[int'(win_idx)*LEN_W +: LEN_W];
    assign issue      = (state == ISSUE);
    assign last_issue = issue && (cnt_q == LEN_W'(1));
    assign rd_valid   = pv[RD_LAT-1];
    assign rd_id      = pid[RD_LAT-1];
    assign rd_last    = pv[RD_LAT-1] & pl[RD_LAT-1];
    assign rd_data    = bram_dout;
    assign out_last   = rd_valid & rd_last;
    // Zero-length bursts never enter the pipeline, so they finish on their own pulse
    assign drain_exit = (state == DRAIN) && (out_last || zl_done_q);
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        grant_n = '0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    grant_n = win_oh;
                    state_n = (win_len == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE:   if (last_issue) state_n = DRAIN;
            DRAIN:   if (drain_exit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        done = '0;
        if (zl_done_q)
            done = NUM_REQ'(1) << id_q;
        else if (out_last)
            done = NUM_REQ'(1) << rd_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            rr_ptr    <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            zl_q      <= 1'b0;
            zl_done_q <= 1'b0;
            bram_en   <= 1'b0;
            bram_ren  <= 1'b0;
            bram_addr <= '0;
            iss_id    <= '0;
            iss_last  <= 1'b0;
            pv        <= '0;
            pl        <= '0;
            for (int i = 0; i < RD_LAT; i++) pid[i] <= '0;
        end else begin
            grant <= grant_n;
            if (state == IDLE && win_any) begin
                rr_ptr <= ID_W'((int'(win_idx) + 1) % NUM_REQ);
                id_q   <= win_idx;
                addr_q <= win_base;
                cnt_q  <= win_len;
                zl_q   <= (win_len == '0);
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                cnt_q  <= cnt_q - LEN_W'(1);
            end
            zl_done_q <= (state == DRAIN) && zl_q && !zl_done_q;
            bram_ren  <= issue;
            bram_addr <= issue ? addr_q : '0;
            // Enable stays up through drain so in-flight reads complete
            bram_en   <= issue | (bram_en & (state == DRAIN) & ~drain_exit);
            iss_id    <= id_q;
            iss_last  <= last_issue;
            // Issue-stage tag plus RD_LAT stages lines the tag up with bram_dout
            pv[0]  <= bram_ren;
            pl[0]  <= bram_ren & iss_last;
            pid[0] <= iss_id;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i]  <= pv[i-1];
                pl[i]  <= pl[i-1];
                pid[i] <= pid[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb/tb_bram_read_arbiter.sv - scoreboard bench for bram_read_arbiter
module tb_bram_read_arbiter;
    import bram_read_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int AW      = 15;
    localparam int LEN_W   = 16;
    localparam int W       = 8;
    localparam int RD_LAT  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*AW-1:0]   req_base;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]      grant, done;
    logic                    busy, rd_valid, rd_last, bram_en, bram_ren;
    logic [ID_W-1:0]         rd_id;
    logic [W-1:0]            rd_data, bram_dout;
    logic [AW-1:0]           bram_addr, a1;

    always #5 clk = ~clk;

    bram_read_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_WIDTH(AW),
        .LEN_W(LEN_W), .W(W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_base(req_base), .req_len(req_len),
        .grant(grant), .done(done), .busy(busy), .rd_valid(rd_valid), .rd_id(rd_id),
        .rd_data(rd_data), .rd_last(rd_last), .bram_en(bram_en), .bram_ren(bram_ren),
        .bram_addr(bram_addr), .bram_dout(bram_dout)
    );

    function automatic logic [7:0] mem_f(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]};
    endfunction

    // Two-cycle synchronous-read BRAM
    always @(posedge clk) begin
        a1        <= bram_addr;
        bram_dout <= mem_f(a1);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct {
        int id;
        int base;
        int len;
        bit chained;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    bit   act_b = 1'b0;
    int   g_cyc, b_id, b_base, b_len, ka, kr;
    int   last_done = 0;
    int   grant3_cnt = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            act_b = 1'b0;
        end else begin
            if (grant != 0) begin
                if (grant[3]) grant3_cnt++;
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", grant, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", grant, 1 << e.id);
                    chk("busy_at_grant", busy, 1);
                    if (e.chained) chk("grant_gap", cyc, last_done + 2);
                    act_b = 1'b1; g_cyc = cyc; b_id = e.id; b_base = e.base; b_len = e.len;
                    ka = 0; kr = 0;
                end
            end
            if (bram_ren) begin
                if (!act_b || ka >= b_len) chk("ren_spurious", bram_ren, 0);
                else begin
                    chk("bram_addr", bram_addr, (b_base + ka) % 32768);
                    chk("addr_cycle", cyc, g_cyc + 1 + ka);
                    chk("bram_en", bram_en, 1);
                    ka++;
                end
            end
            if (rd_valid) begin
                if (!act_b || kr >= b_len) chk("rd_spurious", rd_valid, 0);
                else begin
                    chk("rd_id", rd_id, b_id);
                    chk("rd_data", rd_data, mem_f(AW'(b_base + kr)));
                    chk("rd_last", rd_last, (kr == b_len - 1) ? 1 : 0);
                    chk("rd_cycle", cyc, g_cyc + 1 + RD_LAT + kr);
                    kr++;
                end
            end
            if (done != 0) begin
                if (!act_b) chk("done_spurious", done, 0);
                else begin
                    chk("done_id", done, 1 << b_id);
                    chk("done_cycle", cyc, g_cyc + ((b_len == 0) ? 1 : b_len + RD_LAT));
                    if (b_len == 0) chk("zero_len_no_rd", rd_valid, 0);
                    last_done = cyc;
                    done_cnt++;
                    act_b = 1'b0;
                end
            end
        end
    end

    task automatic set_client(input int i, input int base, input int len);
        req_base[i*AW +: AW]       = AW'(base);
        req_len[i*LEN_W +: LEN_W]  = LEN_W'(len);
    endtask

    task automatic push(input int id, input int base, input int len, input bit chained);
        exp_t x;
        x.id = id; x.base = base; x.len = len; x.chained = chained;
        exp_q.push_back(x);
    endtask

    task automatic wait_grant(input int i);
        bit seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            if (grant[i]) seen = 1'b1;
        end
        if (!seen) chk("grant_timeout", grant[i], 1);
    endtask

    task automatic wait_done(input int i);
        bit seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            if (done[i]) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", done[i], 1);
    endtask

    task automatic single(input int i, input int base, input int len);
        push(i, base, len, 1'b0);
        set_client(i, base, len);
        req = NUM_REQ'(1) << i;
        wait_grant(i);
        req = '0;
        wait_done(i);
        repeat (2) @(negedge clk);
    endtask

    int n;
    int g3_before;

    initial begin
        req = '0; req_base = '0; req_len = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs",
               {grant, done, busy, rd_valid, rd_last, bram_en, bram_ren, bram_addr, rd_id}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Contention: all four held, expect 0,1,2,3,0 back to back
        for (int i = 0; i < 4; i++) set_client(i, 100 * (i + 1), 2);
        push(0, 100, 2, 1'b0);
        push(1, 200, 2, 1'b1);
        push(2, 300, 2, 1'b1);
        push(3, 400, 2, 1'b1);
        push(0, 100, 2, 1'b1);
        req = 4'b1111;
        n = 0;
        for (int t = 0; t < 300 && n < 5; t++) begin
            @(negedge clk);
            if (grant != 0) n++;
        end
        req = '0;
        chk("contention_grants", n, 5);
        wait_done(0);
        repeat (2) @(negedge clk);

        single(0, LAYER1_3_BASE, 4);
        single(2, 500, 0);
        single(1, 32766, 4);

        // Withdrawn request while busy
        g3_before = grant3_cnt;
        push(0, 50, 6, 1'b0);
        set_client(0, 50, 6);
        req = 4'b0001;
        wait_grant(0);
        req = '0;
        @(negedge clk) req = 4'b1000;
        @(negedge clk) req = '0;
        wait_done(0);
        repeat (4) @(negedge clk);
        chk("withdraw_no_grant3", grant3_cnt, g3_before);

        // Reset in the middle of a long burst
        push(0, 1000, 100, 1'b0);
        set_client(0, 1000, 100);
        req = 4'b0001;
        wait_grant(0);
        req = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("midreset_outputs",
               {grant, done, busy, rd_valid, rd_last, bram_en, bram_ren, bram_addr, rd_id}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        single(1, 2000, 3);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, 10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
